// File: rtl/cmi_packet_tx_arbiter.sv
// cmi_packet_tx_arbiter: round-robin sharing of one CMI packet sender among four sources
module cmi_packet_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arb_en,
  input  logic [3:0]   req,
  input  logic [255:0] src_data,
  output logic [3:0]   done,
  output logic [1:0]   gnt_id,
  output logic         busy,
  output logic         send_start,
  output logic [7:0]   send_head,
  output logic [15:0]  send_data0,
  output logic [15:0]  send_data1,
  output logic [15:0]  send_data2,
  output logic [15:0]  send_data3,
  input  logic         send_rdy,
  output logic         timeout_err,
  input  logic         err_clr
);
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, FINISH} state_t;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  state_t      state;
  logic [1:0]  rr_ptr;
  logic [5:0]  seq;
  logic [15:0] wd;
  logic        aborted;
  logic [7:0]  req_rot;
  logic [1:0]  pick;
  assign send_head = {seq, gnt_id};
  // rotate req so bit 0 is the source at rr_ptr, then take the first set bit
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    pick = rr_ptr + (req_rot[0] ? 2'd0 : req_rot[1] ? 2'd1 : req_rot[2] ? 2'd2 : 2'd3);
  end
  // packet FSM: grant, start pulse, sender handshake with watchdog, completion
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      seq         <= '0;
      wd          <= '0;
      aborted     <= 1'b0;
      gnt_id      <= '0;
      send_data0  <= '0;
      send_data1  <= '0;
      send_data2  <= '0;
      send_data3  <= '0;
      done        <= '0;
      send_start  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      send_start <= 1'b0;
      done       <= '0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE:
          if (arb_en && |req) begin
            gnt_id <= pick;
            {send_data3, send_data2, send_data1, send_data0} <= src_data[64*pick +: 64];
            send_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        START: begin
          wd      <= '0;
          aborted <= 1'b0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK, WAIT_DONE: begin
          wd <= wd + 16'd1;
          if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            done        <= 4'b1 << gnt_id;
            state       <= FINISH;
          end else if (state == WAIT_ACK && !send_rdy) begin
            state <= WAIT_DONE;
          end else if (state == WAIT_DONE && send_rdy) begin
            done  <= 4'b1 << gnt_id;
            state <= FINISH;
          end
        end
        FINISH: begin
          rr_ptr <= gnt_id + 2'd1;
          if (!aborted) seq <= seq + 6'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cmi_packet_tx_arbiter.sv
// tb_cmi_packet_tx_arbiter: scoreboard bench for the CMI packet transmit arbiter
module tb_cmi_packet_tx_arbiter;
  typedef struct {
    logic [1:0]  src;
    logic [7:0]  head;
    logic [63:0] data;
  } pkt_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arb_en = 1'b0;
  logic [3:0]   req = '0;
  logic [255:0] src_data = '0;
  logic         send_rdy = 1'b1;
  logic         err_clr = 1'b0;
  logic [3:0]   done;
  logic [1:0]   gnt_id;
  logic         busy, send_start, timeout_err;
  logic [7:0]   send_head;
  logic [15:0]  send_data0, send_data1, send_data2, send_data3;
  logic [3:0]   w_req = '0;
  logic         w_rdy = 1'b1;
  logic         w_clr = 1'b0;
  logic [3:0]   w_done;
  logic [1:0]   w_gnt;
  logic         w_busy, w_start, w_terr;
  logic [7:0]   w_head;
  logic [15:0]  w_d0, w_d1, w_d2, w_d3;
  int nvec = 0, nerr = 0, ndone = 0, nstart = 0;
  int snd_cnt = -1, lo_dly = 2, hi_dly = 100;
  logic [3:0]  exp_done = '0;
  logic [1:0]  m_rr = '0;
  logic [5:0]  m_seq = '0;
  pkt_t        exp_q[$];
  cmi_packet_tx_arbiter #(.TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .src_data(src_data),
    .done(done), .gnt_id(gnt_id), .busy(busy), .send_start(send_start),
    .send_head(send_head), .send_data0(send_data0), .send_data1(send_data1),
    .send_data2(send_data2), .send_data3(send_data3), .send_rdy(send_rdy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );
  cmi_packet_tx_arbiter #(.TIMEOUT_CYC(16)) wdut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(w_req), .src_data(src_data),
    .done(w_done), .gnt_id(w_gnt), .busy(w_busy), .send_start(w_start),
    .send_head(w_head), .send_data0(w_d0), .send_data1(w_d1),
    .send_data2(w_d2), .send_data3(w_d3), .send_rdy(w_rdy),
    .timeout_err(w_terr), .err_clr(w_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] pick_m(input logic [3:0] r, input logic [1:0] rr);
    for (int j = 0; j < 4; j++) if (r[(int'(rr) + j) % 4]) return 2'((int'(rr) + j) % 4);
    return rr;
  endfunction
  task automatic expect_pkt(input logic [3:0] r);
    pkt_t p;
    p.src  = pick_m(r, m_rr);
    p.head = {m_seq, p.src};
    p.data = src_data[64*p.src +: 64];
    exp_q.push_back(p);
    m_rr  = p.src + 2'd1;
    m_seq = m_seq + 6'd1;
  endtask
  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ndone >= target) return;
    end
    chk("wait_done_budget", 64'(ndone), 64'(target));
  endtask
  task automatic wait_wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy && !send_rdy) return;
    end
    chk("wait_sender_low_budget", 64'(send_rdy), 64'd0);
  endtask
  // sender model plus scoreboard monitor, all on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      snd_cnt  = -1;
      send_rdy = 1'b1;
    end else begin
      if (snd_cnt >= 0) begin
        snd_cnt++;
        if (snd_cnt == lo_dly) send_rdy = 1'b0;
        if (snd_cnt == lo_dly + hi_dly) begin
          send_rdy = 1'b1;
          snd_cnt  = -1;
        end
      end
      if (send_start) begin
        pkt_t p;
        nstart++;
        snd_cnt = 0;
        chk("start_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          chk("gnt_id", 64'(gnt_id), 64'(p.src));
          chk("send_head", 64'(send_head), 64'(p.head));
          chk("send_data", {send_data3, send_data2, send_data1, send_data0}, p.data);
          chk("busy_at_start", 64'(busy), 64'd1);
          exp_done = 4'b1 << p.src;
        end
      end
      if (done != 0) begin
        ndone++;
        chk("done_vec", 64'(done), 64'(exp_done));
      end
    end
  end
  initial begin
    int base, n;
    logic [63:0] held;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(send_start), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_head", 64'(send_head), 64'd0);
    chk("rst_data", {send_data3, send_data2, send_data1, send_data0}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    arb_en = 1'b1;
    // watchdog on the second instance: sender never drops ready
    w_req = 4'b0001;
    for (int i = 0; i < 20 && !w_start; i++) begin @(posedge clk); #1; end
    chk("wd_start_seen", 64'(w_start), 64'd1);
    n = 0;
    for (int i = 0; i < 60 && w_done == 0; i++) begin @(posedge clk); #1; n++; end
    chk("wd_done_latency", 64'(n), 64'd17);
    chk("wd_done_vec", 64'(w_done), 64'h1);
    chk("wd_terr_set", 64'(w_terr), 64'd1);
    w_req = '0;
    @(posedge clk); #1;
    chk("wd_seq_unchanged", 64'(w_head), 64'h00);
    w_clr = 1'b1;
    @(posedge clk); #1;
    w_clr = 1'b0;
    chk("wd_terr_cleared", 64'(w_terr), 64'd0);
    // single request, slow sender
    src_data[63:0] = 64'h4444_3333_2222_1111;
    expect_pkt(4'b0001);
    req = 4'b0001;
    wait_dones(1, 400);
    req = '0;
    repeat (3) @(posedge clk); #1;
    chk("single_done_once", 64'(ndone), 64'd1);
    chk("single_seq1", 64'(send_head), 64'h04);
    chk("main_terr_clear", 64'(timeout_err), 64'd0);
    hi_dly = 5;
    // round robin over all four sources
    for (int s = 0; s < 4; s++) src_data[64*s +: 64] = {4{16'(16'hA000 + s)}};
    for (int k = 0; k < 8; k++) expect_pkt(4'b1111);
    base = ndone;
    req = 4'b1111;
    wait_dones(base + 8, 400);
    req = '0;
    // fairness with two competing sources
    for (int k = 0; k < 4; k++) expect_pkt(4'b0101);
    base = ndone;
    req = 4'b0101;
    wait_dones(base + 4, 300);
    req = '0;
    // data stability: change source words while the packet is on the wire
    src_data[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
    held = src_data[127:64];
    expect_pkt(4'b0010);
    base = ndone;
    req = 4'b0010;
    wait_wait_done(50);
    src_data = ~src_data;
    wait_dones(base + 1, 100);
    req = '0;
    chk("data_stable", {send_data3, send_data2, send_data1, send_data0}, held);
    // run until the 6-bit sequence number wraps
    n = 0;
    while (m_seq != 0) begin expect_pkt(4'b1111); n++; end
    base = ndone;
    req = 4'b1111;
    wait_dones(base + n, 2000);
    req = '0;
    @(posedge clk); #1;
    chk("seq_wrap", 64'(send_head[7:2]), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    // grants disabled
    arb_en = 1'b0;
    base = nstart;
    req = 4'b1111;
    repeat (20) @(posedge clk); #1;
    chk("arb_off_no_start", 64'(nstart), 64'(base));
    chk("arb_off_busy", 64'(busy), 64'd0);
    // reset in the middle of a packet
    expect_pkt(4'b1111);
    arb_en = 1'b1;
    wait_wait_done(50);
    base = ndone;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_head", 64'(send_head), 64'd0);
    m_rr = '0;
    m_seq = '0;
    repeat (3) @(posedge clk);
    chk("midrst_no_done", 64'(ndone), 64'(base));
    expect_pkt(4'b1111);
    #1 rst = 1'b0;
    wait_dones(base + 1, 100);
    req = '0;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_queue", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
